// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data port.
// One transaction in flight; a fetch withdrawn while busy completes but its response is dropped.
module mem_arbiter #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req_active,
  input  logic [RW-1:0]     i_f_req_addr,
  output logic [I_SIZE-1:0] o_f_req_data,
  output logic              o_f_req_data_valid,
  input  logic              i_d_req_active,
  input  logic              i_d_req_we,
  input  logic [RW-1:0]     i_d_req_addr,
  input  logic [RW-1:0]     i_d_req_wdata,
  output logic [RW-1:0]     o_d_req_data,
  output logic              o_d_req_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [RW-1:0]     o_mem_addr,
  output logic [RW-1:0]     o_mem_wdata,
  input  logic [I_SIZE-1:0] i_mem_data,
  input  logic              i_mem_ack
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_F = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              f_abort_q, f_abort_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [RW-1:0]     mem_addr_q, mem_addr_d;
  logic [RW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [I_SIZE-1:0] f_data_q, f_data_d;
  logic              f_valid_q, f_valid_d;
  logic [RW-1:0]     d_data_q, d_data_d;
  logic              d_ack_q, d_ack_d;
  logic              grant_f_s, grant_d_s, abort_now_s;

  // Next-state, grant selection and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    f_abort_d    = f_abort_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f_data_d     = f_data_q;
    f_valid_d    = 1'b0;
    d_data_d     = d_data_q;
    d_ack_d      = 1'b0;
    // On a tie the requester that did not win last time is served.
    grant_f_s    = i_f_req_active && (!i_d_req_active || (last_grant_q == 1'b1));
    grant_d_s    = i_d_req_active && (!i_f_req_active || (last_grant_q == 1'b0));
    abort_now_s  = f_abort_q || !i_f_req_active;
    case (state_q)
      IDLE: begin
        if (grant_f_s) begin
          state_d      = BUSY_F;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_f_req_addr;
          mem_wdata_d  = {RW{1'b0}};
          last_grant_d = 1'b0;
          f_abort_d    = 1'b0;
        end else if (grant_d_s) begin
          state_d      = BUSY_D;
          mem_req_d    = 1'b1;
          mem_we_d     = i_d_req_we;
          mem_addr_d   = i_d_req_addr;
          mem_wdata_d  = i_d_req_wdata;
          last_grant_d = 1'b1;
          f_abort_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_F: begin
        f_abort_d = abort_now_s;
        if (i_mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          f_data_d  = i_mem_data;
          f_valid_d = !abort_now_s;
        end else begin
          state_d = BUSY_F;
        end
      end
      BUSY_D: begin
        if (i_mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_data_d  = i_mem_data[RW-1:0];
          d_ack_d   = 1'b1;
        end else begin
          state_d = BUSY_D;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      f_abort_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {RW{1'b0}};
      mem_wdata_q  <= {RW{1'b0}};
      f_data_q     <= {I_SIZE{1'b0}};
      f_valid_q    <= 1'b0;
      d_data_q     <= {RW{1'b0}};
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      f_abort_q    <= f_abort_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      f_data_q     <= f_data_d;
      f_valid_q    <= f_valid_d;
      d_data_q     <= d_data_d;
      d_ack_q      <= d_ack_d;
    end
  end

  assign o_mem_req          = mem_req_q;
  assign o_mem_we           = mem_we_q;
  assign o_mem_addr         = mem_addr_q;
  assign o_mem_wdata        = mem_wdata_q;
  assign o_f_req_data       = f_data_q;
  assign o_f_req_data_valid = f_valid_q;
  assign o_d_req_data       = d_data_q;
  assign o_d_req_ack        = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: inputs driven and outputs sampled on the falling edge,
// expected responses queued when the memory answer is driven and popped when the pulse appears.
module tb_mem_arbiter;

  localparam int RW     = 16;
  localparam int I_SIZE = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              f_act = 1'b0;
  logic [RW-1:0]     f_addr = 16'h0000;
  logic [I_SIZE-1:0] o_f_req_data;
  logic              o_f_req_data_valid;
  logic              d_act = 1'b0;
  logic              d_we = 1'b0;
  logic [RW-1:0]     d_addr = 16'h0000;
  logic [RW-1:0]     d_wdata = 16'h0000;
  logic [RW-1:0]     o_d_req_data;
  logic              o_d_req_ack;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [RW-1:0]     o_mem_addr;
  logic [RW-1:0]     o_mem_wdata;
  logic [I_SIZE-1:0] mem_data = 32'h0000_0000;
  logic              mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] f_q[$];
  logic [15:0] d_q[$];
  logic [15:0] g_q[$];

  mem_arbiter #(.RW(RW), .I_SIZE(I_SIZE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_f_req_active(f_act), .i_f_req_addr(f_addr),
    .o_f_req_data(o_f_req_data), .o_f_req_data_valid(o_f_req_data_valid),
    .i_d_req_active(d_act), .i_d_req_we(d_we), .i_d_req_addr(d_addr),
    .i_d_req_wdata(d_wdata), .o_d_req_data(o_d_req_data), .o_d_req_ack(o_d_req_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_data(mem_data), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [83:0] all_out();
    return {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_f_req_data,
            o_f_req_data_valid, o_d_req_data, o_d_req_ack};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out() !== 84'h0) begin
      errors++; $display("FAIL reset_values: got %h expected 0", all_out());
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    logic [31:0] exp;
    @(negedge clk); f_act = 1'b1; f_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0010 || o_mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_bus: req=%b addr=%h we=%b expected 1 0010 0", o_mem_req, o_mem_addr, o_mem_we);
    end
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; f_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); mem_ack = 1'b0; f_act = 1'b0;
    exp = f_q.pop_front();
    checks++;
    if (o_f_req_data_valid !== 1'b1 || o_f_req_data !== exp || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_resp: valid=%b data=%h req=%b expected 1 %h 0", o_f_req_data_valid, o_f_req_data, o_mem_req, exp);
    end
    @(negedge clk);
    checks++;
    if (o_f_req_data_valid !== 1'b0 || o_f_req_data !== exp) begin
      errors++; $display("FAIL fetch_pulse_width: valid=%b data=%h expected 0 %h", o_f_req_data_valid, o_f_req_data, exp);
    end
  endtask

  task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic [31:0] rdata);
    logic [15:0] exp;
    @(negedge clk); d_act = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_we !== we || o_mem_addr !== addr || o_d_req_ack !== 1'b0 ||
          (we && o_mem_wdata !== wd)) begin
        errors++; $display("FAIL data_hold_%0d: req=%b we=%b addr=%h wdata=%h ack=%b expected 1 %b %h %h 0",
                           i, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_d_req_ack, we, addr, wd);
      end
      if (i == 3) begin
        mem_ack = 1'b1; mem_data = rdata; d_q.push_back(rdata[15:0]);
      end
    end
    @(negedge clk); mem_ack = 1'b0; d_act = 1'b0;
    exp = d_q.pop_front();
    checks++;
    if (o_d_req_ack !== 1'b1 || o_f_req_data_valid !== 1'b0 || (!we && o_d_req_data !== exp)) begin
      errors++; $display("FAIL data_resp: ack=%b data=%h expected 1 %h", o_d_req_ack, o_d_req_data, exp);
    end
  endtask

  task automatic test_store_load();
    data_txn(1'b1, 16'h0200, 16'h1234, 32'h0000_0000);
    data_txn(1'b0, 16'h0200, 16'h1234, 32'h0000_1234);
    @(negedge clk);
    checks++;
    if (o_d_req_ack !== 1'b0 || o_mem_req !== 1'b0 || o_d_req_data !== 16'h1234) begin
      errors++; $display("FAIL load_hold: ack=%b req=%b data=%h expected 0 0 1234", o_d_req_ack, o_mem_req, o_d_req_data);
    end
  endtask

  task automatic test_contention();
    int fc = 0;
    int dc = 0;
    int gi = 0;
    logic [15:0] ga;
    rst = 1'b1; f_act = 1'b1; f_addr = 16'h0100;
    d_act = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    g_q.push_back(16'h0100); g_q.push_back(16'h0300);
    g_q.push_back(16'h0100); g_q.push_back(16'h0300);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (o_f_req_data_valid === 1'b1 && o_d_req_ack === 1'b1) begin
        errors++; $display("FAIL pulse_overlap_c%0d: valid=1 ack=1 expected not both", c);
      end
      if (o_f_req_data_valid === 1'b1) begin
        fc++; checks++;
        if (f_q.size() == 0 || o_f_req_data !== f_q[0]) begin
          errors++; $display("FAIL cont_fetch_data: got %h queue_size=%0d", o_f_req_data, f_q.size());
        end
        if (f_q.size() != 0) void'(f_q.pop_front());
      end
      if (o_d_req_ack === 1'b1) begin
        dc++; checks++;
        if (d_q.size() == 0 || o_d_req_data !== d_q[0]) begin
          errors++; $display("FAIL cont_data_data: got %h queue_size=%0d", o_d_req_data, d_q.size());
        end
        if (d_q.size() != 0) void'(d_q.pop_front());
      end
      if (o_mem_req === 1'b1) begin
        checks++;
        ga = (g_q.size() != 0) ? g_q.pop_front() : 16'hFFFF;
        if (o_mem_addr !== ga) begin
          errors++; $display("FAIL grant_order_%0d: addr=%h expected %h", gi, o_mem_addr, ga);
        end
        mem_ack = 1'b1;
        mem_data = 32'hA5A5_0000 | gi;
        if (ga == 16'h0100) f_q.push_back(mem_data);
        else d_q.push_back(mem_data[15:0]);
        gi++;
      end
      if (c == 7) begin
        f_act = 1'b0; d_act = 1'b0;
      end
    end
    checks++;
    if (fc != 2 || dc != 2) begin
      errors++; $display("FAIL cont_counts: fetch=%0d data=%0d expected 2 2", fc, dc);
    end
    @(negedge clk); mem_ack = 1'b0;
    f_q.delete(); d_q.delete(); g_q.delete();
  endtask

  task automatic test_fetch_abort();
    logic [31:0] exp;
    @(negedge clk); f_act = 1'b1; f_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0040) begin
      errors++; $display("FAIL abort_grant: req=%b addr=%h expected 1 0040", o_mem_req, o_mem_addr);
    end
    f_act = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_data = 32'hBAD0_BAD0; f_act = 1'b1; f_addr = 16'h0080;
    @(negedge clk); mem_ack = 1'b0;
    checks++;
    if (o_f_req_data_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_suppress: valid=%b req=%b expected 0 0", o_f_req_data_valid, o_mem_req);
    end
    @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0080) begin
      errors++; $display("FAIL abort_regrant: req=%b addr=%h expected 1 0080", o_mem_req, o_mem_addr);
    end
    mem_ack = 1'b1; mem_data = 32'hCAFE_0080; f_q.push_back(32'hCAFE_0080);
    @(negedge clk); mem_ack = 1'b0; f_act = 1'b0;
    exp = f_q.pop_front();
    checks++;
    if (o_f_req_data_valid !== 1'b1 || o_f_req_data !== exp) begin
      errors++; $display("FAIL abort_next_resp: valid=%b data=%h expected 1 %h", o_f_req_data_valid, o_f_req_data, exp);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); d_act = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h7777;
    @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1) begin
      errors++; $display("FAIL rmid_busy: req=%b we=%b expected 1 1", o_mem_req, o_mem_we);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; d_act = 1'b0;
    checks++;
    if (all_out() !== 84'h0) begin
      errors++; $display("FAIL rmid_reset_values: got %h expected 0", all_out());
    end
    @(negedge clk);
    @(negedge clk); mem_ack = 1'b1; mem_data = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b0;
      checks++;
      if (all_out() !== 84'h0) begin
        errors++; $display("FAIL rmid_stale_ack_%0d: got %h expected 0", i, all_out());
      end
    end
  endtask

  task automatic test_stale_ack();
    logic [31:0] exp;
    @(negedge clk); mem_ack = 1'b1; mem_data = 32'h55AA_55AA;
    @(negedge clk); mem_ack = 1'b0;
    checks++;
    if (all_out() !== 84'h0) begin
      errors++; $display("FAIL idle_ack: got %h expected 0", all_out());
    end
    f_act = 1'b1; f_addr = 16'h0022;
    @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0022) begin
      errors++; $display("FAIL idle_after_ack: req=%b addr=%h expected 1 0022", o_mem_req, o_mem_addr);
    end
    mem_ack = 1'b1; mem_data = 32'h0BAD_F00D; f_q.push_back(32'h0BAD_F00D);
    @(negedge clk); mem_ack = 1'b0; f_act = 1'b0;
    exp = f_q.pop_front();
    checks++;
    if (o_f_req_data_valid !== 1'b1 || o_f_req_data !== exp) begin
      errors++; $display("FAIL idle_fetch_resp: valid=%b data=%h expected 1 %h", o_f_req_data_valid, o_f_req_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_fetch_abort();
    test_reset_mid();
    test_stale_ack();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
